// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL supervisor: state encoding and counter sizing.
package pll_sup_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] PLL_RST   = 3'd0;
    localparam logic [STATE_W-1:0] WAIT_LOCK = 3'd1;
    localparam logic [STATE_W-1:0] STABLE    = 3'd2;
    localparam logic [STATE_W-1:0] RELEASE   = 3'd3;
    localparam logic [STATE_W-1:0] RUN       = 3'd4;

    // Width of a counter that must reach the largest of the given terminal counts.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; clears to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic q_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/pll_supervisor.sv
// PLL lock supervisor and staged reset sequencer on the free-running reference clock.
// Drives PLL RESETB, waits for a stable lock, then releases domain resets in order.
module pll_supervisor
    import pll_sup_pkg::*;
#(
    parameter int NUM_DOMAINS    = 3,
    parameter int PLL_RST_CYCLES = 24,
    parameter int LOCK_TIMEOUT   = 12000,
    parameter int STABLE_CYCLES  = 1200,
    parameter int STAGE_GAP      = 16,
    parameter int CNT_W          = 8
) (
    input  logic                   REFERENCECLK,
    input  logic                   RESET,
    input  logic                   LOCK,
    input  logic                   FORCE_RELOCK,
    input  logic                   CLEAR_COUNT,
    output logic                   PLL_RESETB,
    output logic [NUM_DOMAINS-1:0] DOMAIN_RESET,
    output logic                   READY,
    output logic [CNT_W-1:0]       LOSS_COUNT
);

    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES,
                                  (NUM_DOMAINS - 1) * STAGE_GAP);

    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] REL_LAST = CW'((NUM_DOMAINS - 1) * STAGE_GAP);

    logic                   lock_s;
    logic [STATE_W-1:0]     state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   loss_evt;
    logic                   pll_resetb_q, pll_resetb_d;
    logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
    logic                   ready_q, ready_d;
    logic [CNT_W-1:0]       loss_cnt_q, loss_cnt_d;

    sync_2ff u_lock_sync (
        .clk   (REFERENCECLK),
        .rst   (RESET),
        .d_in  (LOCK),
        .q_out (lock_s)
    );

    always_ff @(posedge REFERENCECLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= PLL_RST;
            cnt_q        <= '0;
            pll_resetb_q <= 1'b0;
            dom_rst_q    <= '1;
            ready_q      <= 1'b0;
            loss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pll_resetb_q <= pll_resetb_d;
            dom_rst_q    <= dom_rst_d;
            ready_q      <= ready_d;
            loss_cnt_q   <= loss_cnt_d;
        end
    end

    // FORCE_RELOCK wins over every other exit, but a coincident loss is still counted.
    always_comb begin
        state_d  = state_q;
        loss_evt = 1'b0;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (FORCE_RELOCK)           state_d = PLL_RST;
                else if (lock_s)            state_d = STABLE;
                else if (cnt_q == TO_LAST)  state_d = PLL_RST;
            end
            STABLE: begin
                if (FORCE_RELOCK)           state_d = PLL_RST;
                else if (!lock_s)           state_d = WAIT_LOCK;
                else if (cnt_q == STB_LAST) state_d = RELEASE;
            end
            RELEASE, RUN: begin
                loss_evt = !lock_s;
                if (FORCE_RELOCK)           state_d = PLL_RST;
                else if (!lock_s)           state_d = WAIT_LOCK;
                else if (state_q == RELEASE && cnt_q == REL_LAST) state_d = RUN;
            end
            default: state_d = PLL_RST;
        endcase

        if (state_d != state_q)  cnt_d = '0;
        else if (state_q == RUN) cnt_d = cnt_q;
        else                     cnt_d = cnt_q + CW'(1);
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_comb begin
        pll_resetb_d = (state_d != PLL_RST);
        ready_d      = (state_d == RUN);
        dom_rst_d    = '1;
        if (state_d == RUN) begin
            dom_rst_d = '0;
        end else if (state_d == RELEASE) begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                dom_rst_d[i] = (cnt_d < CW'(i * STAGE_GAP));
            end
        end

        if (CLEAR_COUNT)                        loss_cnt_d = loss_evt ? CNT_W'(1) : '0;
        else if (loss_evt && loss_cnt_q != '1)  loss_cnt_d = loss_cnt_q + CNT_W'(1);
        else                                    loss_cnt_d = loss_cnt_q;
    end

    assign PLL_RESETB   = pll_resetb_q;
    assign DOMAIN_RESET = dom_rst_q;
    assign READY        = ready_q;
    assign LOSS_COUNT   = loss_cnt_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Randomised bench for pll_supervisor against a timeline-based reference model of the
// supervisor (phase + entry cycle, release pattern derived arithmetically from elapsed time).
module tb_pll_supervisor;

    localparam int ND   = 3;
    localparam int PRC  = 5;
    localparam int TO   = 40;
    localparam int STC  = 8;
    localparam int GAP  = 4;
    localparam int LCW  = 4;
    localparam int LMAX = (1 << LCW) - 1;

    localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_REL = 3, P_RUN = 4;

    logic            clk;
    logic            rst, lock, frc, clr;
    logic            resetb_o;
    logic [ND-1:0]   dom_o;
    logic            ready_o;
    logic [LCW-1:0]  loss_o;
    logic [8:0]      dut_vec;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: current phase, cycle it was entered, expected loss count,
    // and the last two applied LOCK values (what the synchroniser delivers two cycles later).
    int   phase, entry, cyc, exp_loss;
    logic lk1, lk2;

    pll_supervisor #(
        .NUM_DOMAINS    (ND),
        .PLL_RST_CYCLES (PRC),
        .LOCK_TIMEOUT   (TO),
        .STABLE_CYCLES  (STC),
        .STAGE_GAP      (GAP),
        .CNT_W          (LCW)
    ) dut (
        .REFERENCECLK (clk),
        .RESET        (rst),
        .LOCK         (lock),
        .FORCE_RELOCK (frc),
        .CLEAR_COUNT  (clr),
        .PLL_RESETB   (resetb_o),
        .DOMAIN_RESET (dom_o),
        .READY        (ready_o),
        .LOSS_COUNT   (loss_o)
    );

    assign dut_vec = {resetb_o, dom_o, ready_o, loss_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, want summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] exp_vec();
        logic [2:0] d;
        int age;
        age = cyc - entry;
        d = 3'b111;
        if (phase == P_RUN) d = 3'b000;
        else if (phase == P_REL)
            for (int i = 0; i < ND; i++) d[i] = (age < i * GAP);
        return {phase != P_RST, d, phase == P_RUN, exp_loss[3:0]};
    endfunction

    task automatic model_reset();
        phase = P_RST; entry = 0; cyc = 0; exp_loss = 0; lk1 = 1'b0; lk2 = 1'b0;
    endtask

    task automatic model_step();
        int   age, nxt;
        logic ls, loss;
        age = cyc - entry; ls = lk2; nxt = phase; loss = 1'b0;
        case (phase)
            P_RST:  if (age == PRC - 1) nxt = P_WAIT;
            P_WAIT: if (frc) nxt = P_RST; else if (ls) nxt = P_STB; else if (age == TO - 1) nxt = P_RST;
            P_STB:  if (frc) nxt = P_RST; else if (!ls) nxt = P_WAIT; else if (age == STC - 1) nxt = P_REL;
            default: begin
                loss = !ls;
                if (frc) nxt = P_RST;
                else if (loss) nxt = P_WAIT;
                else if (phase == P_REL && age == (ND - 1) * GAP) nxt = P_RUN;
            end
        endcase
        if (clr) exp_loss = loss ? 1 : 0;
        else if (loss && exp_loss < LMAX) exp_loss++;
        cyc++;
        if (nxt != phase) begin phase = nxt; entry = cyc; end
        lk2 = lk1; lk1 = lock;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic hard_reset();
        rst = 1'b1; lock = 1'b0; frc = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic reach_ready(input string tag, input int budget);
        int n;
        n = 0;
        while (ready_o !== 1'b1 && n < budget) begin
            tick(); n++;
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL %s cyc=%0d got=%b want=%b", tag, cyc, dut_vec, exp_vec());
            end
        end
        vectors++;
        if (ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_timeout READY=%b want 1", tag, ready_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; lock = 1'b1; frc = 1'b0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (dut_vec !== 9'b0_111_0_0000) begin
            miscompares++;
            $display("FAIL reset_values got=%b want=%b", dut_vec, 9'b0_111_0_0000);
        end
        rst = 1'b0; lock = 1'b0;
        model_reset();
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_release got=%b want=%b", dut_vec, exp_vec());
        end
    endtask

    task automatic test_powerup();
        logic [2:0] pat[$];
        int         at[$];
        logic [2:0] prev;
        logic [2:0] want_pat[3];
        int         want_at[3];
        int         lows;
        want_pat = '{3'b110, 3'b100, 3'b000};
        want_at  = '{26, 30, 34};
        hard_reset();
        prev = 3'b111;
        lows = (resetb_o === 1'b0) ? 1 : 0;
        for (int n = 0; n < 80 && ready_o !== 1'b1; n++) begin
            if (cyc == 15) lock = 1'b1;
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL powerup cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec());
            end
            if (resetb_o === 1'b0) lows++;
            if (dom_o !== prev) begin pat.push_back(dom_o); at.push_back(cyc); prev = dom_o; end
        end
        vectors++;
        if (lows != PRC) begin
            miscompares++;
            $display("FAIL powerup_resetb_low got=%0d want=%0d", lows, PRC);
        end
        vectors++;
        if (pat.size() != 3) begin
            miscompares++;
            $display("FAIL powerup_release_steps got=%0d want=3", pat.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (pat[i] !== want_pat[i] || at[i] != want_at[i]) begin
                    miscompares++;
                    $display("FAIL powerup_stage%0d got=%b@%0d want=%b@%0d", i, pat[i], at[i], want_pat[i], want_at[i]);
                end
            end
        end
        vectors++;
        if (ready_o !== 1'b1 || cyc != 35 || loss_o !== 4'd0) begin
            miscompares++;
            $display("FAIL powerup_ready got=%b@%0d loss=%0d want=1@35 loss=0", ready_o, cyc, loss_o);
        end
    endtask

    task automatic test_no_lock();
        logic [4:0] want;
        hard_reset();
        for (int n = 0; n < 3 * (PRC + TO); n++) begin
            tick();
            want = {(cyc % (PRC + TO)) >= PRC, 3'b111, 1'b0};
            vectors++;
            if ({resetb_o, dom_o, ready_o} !== want || dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL no_lock cyc=%0d got=%b want=%b model=%b", cyc, dut_vec, want, exp_vec());
            end
        end
    endtask

    task automatic test_glitch();
        int k, t_lock, g, first_rel;
        hard_reset();
        k = $urandom_range(0, 15);
        t_lock = PRC + k;
        g = t_lock + 3 + $urandom_range(0, 5);
        first_rel = -1;
        for (int n = 0; n < 120 && ready_o !== 1'b1; n++) begin
            if (cyc == t_lock) lock = 1'b1;
            if (cyc == g) lock = 1'b0;
            if (cyc == g + 3) lock = 1'b1;
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL glitch cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec());
            end
            if (first_rel < 0 && dom_o !== 3'b111) first_rel = cyc;
        end
        vectors++;
        if (first_rel != g + 14 || loss_o !== 4'd0 || ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_release got=%0d loss=%0d ready=%b want=%0d loss=0 ready=1",
                     first_rel, loss_o, ready_o, g + 14);
        end
    endtask

    task automatic test_loss_in_run();
        hard_reset();
        lock = 1'b1;
        reach_ready("loss_bringup", 60);
        repeat ($urandom_range(0, 5)) tick();
        lock = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL loss_drop cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec());
            end
        end
        vectors++;
        if ({dom_o, ready_o, loss_o} !== {3'b111, 1'b0, 4'd1}) begin
            miscompares++;
            $display("FAIL loss_response got=%b want=%b", {dom_o, ready_o, loss_o}, {3'b111, 1'b0, 4'd1});
        end
        repeat ($urandom_range(1, 10)) tick();
        lock = 1'b1;
        reach_ready("loss_relock", 60);
        for (int r = 0; r < 20; r++) begin
            lock = 1'b0;
            repeat ($urandom_range(3, 6)) tick();
            lock = 1'b1;
            reach_ready("loss_sat", 60);
        end
        vectors++;
        if (loss_o !== 4'd15) begin
            miscompares++;
            $display("FAIL loss_saturate got=%0d want=15", loss_o);
        end
    endtask

    task automatic test_force();
        int lows;
        hard_reset();
        lock = 1'b1;
        reach_ready("force_bringup", 60);
        frc = 1'b1; tick(); frc = 1'b0;
        lows = (resetb_o === 1'b0) ? 1 : 0;
        reach_ready("force_plain", 80);
        for (int n = 0; n < 0; n++) lows++;
        lows = lows + 0;
        vectors++;
        if (loss_o !== 4'd0) begin
            miscompares++;
            $display("FAIL force_plain_loss got=%0d want=0", loss_o);
        end
        // Coincident case: assert FORCE_RELOCK in the cycle the synchronised lock is low.
        lock = 1'b0;
        tick(); tick();
        frc = 1'b1; tick(); frc = 1'b0;
        lock = 1'b1;
        lows = 0;
        for (int n = 0; n < 80 && ready_o !== 1'b1; n++) begin
            if (resetb_o === 1'b0) lows++;
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL force_loss cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec());
            end
        end
        vectors++;
        if (lows != PRC || loss_o !== 4'd1 || ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL force_loss_summary lows=%0d loss=%0d ready=%b want lows=%0d loss=1 ready=1",
                     lows, loss_o, ready_o, PRC);
        end
    endtask

    task automatic test_force_pulse_width();
        int lows;
        hard_reset();
        lock = 1'b1;
        reach_ready("pulse_bringup", 60);
        frc = 1'b1; tick(); frc = 1'b0;
        lows = 0;
        for (int n = 0; n < 80 && ready_o !== 1'b1; n++) begin
            if (resetb_o === 1'b0) lows++;
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL force_pulse cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec());
            end
        end
        vectors++;
        if (lows != PRC || loss_o !== 4'd0) begin
            miscompares++;
            $display("FAIL force_pulse_summary lows=%0d loss=%0d want lows=%0d loss=0", lows, loss_o, PRC);
        end
    endtask

    task automatic test_clear();
        hard_reset();
        lock = 1'b1;
        reach_ready("clear_bringup", 60);
        for (int r = 0; r < 3; r++) begin
            lock = 1'b0;
            repeat (4) tick();
            lock = 1'b1;
            reach_ready("clear_build", 60);
        end
        vectors++;
        if (loss_o !== 4'd3) begin
            miscompares++;
            $display("FAIL clear_build_count got=%0d want=3", loss_o);
        end
        lock = 1'b0;
        tick(); tick();
        clr = 1'b1; tick(); clr = 1'b0;
        vectors++;
        if (loss_o !== 4'd1 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL clear_with_loss got=%0d want=1 (model %b)", loss_o, exp_vec());
        end
        lock = 1'b1;
        reach_ready("clear_relock", 60);
        clr = 1'b1; tick(); clr = 1'b0;
        vectors++;
        if (loss_o !== 4'd0 || ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_alone got=%0d ready=%b want=0 ready=1", loss_o, ready_o);
        end
    endtask

    task automatic test_reset_mid_release();
        int first_rel;
        hard_reset();
        lock = 1'b1;
        for (int n = 0; n < 40 && dom_o === 3'b111; n++) tick();
        tick();
        vectors++;
        if (dom_o !== 3'b110) begin
            miscompares++;
            $display("FAIL midrel_precondition got=%b want=110", dom_o);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (dut_vec !== 9'b0_111_0_0000) begin
            miscompares++;
            $display("FAIL midrel_async_reset got=%b want=%b", dut_vec, 9'b0_111_0_0000);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        first_rel = -1;
        for (int n = 0; n < 60 && ready_o !== 1'b1; n++) begin
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL midrel_replay cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec());
            end
            if (first_rel < 0 && dom_o !== 3'b111) first_rel = cyc;
        end
        vectors++;
        if (first_rel != 14 || ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midrel_replay_timing got=%0d ready=%b want=14 ready=1", first_rel, ready_o);
        end
    endtask

    task automatic test_random();
        hard_reset();
        lock = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            if (lock) begin
                if ($urandom_range(0, 59) == 0) lock = 1'b0;
            end else begin
                if ($urandom_range(0, 9) == 0) lock = 1'b1;
            end
            frc = ($urandom_range(0, 149) == 0);
            clr = ($urandom_range(0, 99) == 0);
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec());
            end
        end
        frc = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_no_lock();
        test_glitch();
        test_loss_in_run();
        test_force();
        test_force_pulse_width();
        test_clear();
        test_reset_mid_release();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
